tb_memory_arbiter: RTL
======================

Name: tb_memory_arbiter

Overview:
- Shares one single-bank testbench memory port among NumPorts requesters using a mem-style req/gnt/rvalid protocol.
- Sits between several memory-bus masters (e.g. multiple AXI-to-mem converters or DMA/debug ports) and the DPI-backed memory model.
- Arbitrates round-robin, locks the selection until the handshake completes, and routes in-order responses back through an ID FIFO.

Parameters:
- NumPorts, 4, number of requesters (>=1).
- AddrWidth, 48, address width.
- DataWidth, 64, data width (multiple of 8).
- MaxOutstanding, 4, downstream requests in flight before new grants stall (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_req_i  in  NumPorts  per-port request.
- in_gnt_o  out  NumPorts  per-port grant (one-hot or zero).
- in_addr_i  in  NumPorts*AddrWidth  per-port address.
- in_we_i  in  NumPorts  per-port write enable.
- in_wdata_i  in  NumPorts*DataWidth  per-port write data.
- in_strb_i  in  NumPorts*DataWidth/8  per-port byte strobe.
- in_rvalid_o  out  NumPorts  per-port response valid.
- in_rdata_o  out  NumPorts*DataWidth  per-port read data (zero when its rvalid is low).
- out_req_o  out  1  downstream request.
- out_gnt_i  in  1  downstream grant.
- out_addr_o  out  AddrWidth  downstream address.
- out_we_o  out  1  downstream write enable.
- out_wdata_o  out  DataWidth  downstream write data.
- out_strb_o  out  DataWidth/8  downstream strobe.
- out_rvalid_i  in  1  downstream response valid (in order, one per granted request, reads and writes).
- out_rdata_i  in  DataWidth  downstream read data.
- outstanding_o  out  $clog2(MaxOutstanding+1)  requests in flight.

Behaviour:
- Reset: rr pointer=0, lock cleared, ID FIFO empty, outstanding_o=0. All request-path outputs are combinational and are zero when no in_req_i is set.
- Arbitration:
  - Winner = first requesting port at or after the rr pointer, wrapping modulo NumPorts.
  - out_req_o = (any in_req_i) & !full, where full = (outstanding == MaxOutstanding).
  - Popping and pushing in the same cycle is allowed only when not full. There is no full-bypass.
- Mux: out_addr_o, out_we_o, out_wdata_o and out_strb_o carry the selected port's fields. When out_req_o is low, they are zero.
- Grant:
  - in_gnt_o[sel] = out_req_o & out_gnt_i. All other bits are 0.
  - Zero-latency feedthrough from out_gnt_i.
- Lock:
  - If out_req_o=1 and out_gnt_i=0, the selected index is registered and held on later cycles until the handshake, even if a higher-priority port raises its request.
  - A requester must hold req and its fields stable until granted. Dropping a locked request is a protocol error: it is flagged by assertion, and the lock is released.
- Handshake (out_req_o & out_gnt_i):
  - Push the winner index into the ID FIFO.
  - rr pointer <= (winner+1) mod NumPorts.
  - Clear the lock.
- Response:
  - On out_rvalid_i, pop the FIFO head h.
  - in_rvalid_o[h]=1 and in_rdata_o[h]=out_rdata_i in the same cycle (combinational).
  - Writes also receive an rvalid; their rdata is passed through unchanged.
- Counters:
  - outstanding = push - pop per cycle. A simultaneous push and pop leaves it unchanged.
  - The FIFO wraps its read and write pointers modulo MaxOutstanding.
- out_rvalid_i with an empty FIFO: response dropped, no in_rvalid_o, outstanding stays 0, assertion fires.
- Reset mid-operation: all state is cleared immediately (asynchronously). Downstream responses still in flight afterwards hit an empty FIFO and are dropped per the previous rule.
- NumPorts=1: the pointer is a constant 0, and the arbiter degenerates to a passthrough plus the FIFO and outstanding limit.

Test Plan:
- Single port, NumPorts=4: port 2 reads 0x1000, memory grants immediately and responds next cycle with 0xDEAD_BEEF → in_gnt_o=4'b0100 in cycle 0; in_rvalid_o=4'b0100 and in_rdata_o[2]=0xDEAD_BEEF in cycle 1; outstanding_o goes 0→1→0.
- All four ports request continuously with out_gnt_i=1 → grant order 0,1,2,3,0,…; each port gets exactly 1 of every 4 grants.
- Lock: port 1 requests with out_gnt_i=0 for 3 cycles while port 0 raises req in cycle 1 → out_addr_o stays at port 1's address; port 1 is granted first on out_gnt_i=1; port 0 is granted next.
- Outstanding limit, MaxOutstanding=4: 4 grants with no rvalid → outstanding_o=4 and out_req_o=0 despite pending requests. One rvalid returns → out_req_o rises the next cycle. Responses come back to ports in grant order, e.g. 3,0,1,2.
- Simultaneous push and pop at outstanding_o=2 → stays 2; the FIFO routes the head response correctly across the wrap boundary.
- Assert rst_ni mid-traffic with 3 outstanding, then deliver 3 rvalids → no in_rvalid_o; outstanding_o=0; the first post-reset grant goes to port 0 when all ports request.

Source files
------------

// File: rtl/tb_memory_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among NumPorts requesters.
// Selection is locked while the downstream stalls; responses are routed back through an ID FIFO.
module tb_memory_arbiter #(
    parameter int NumPorts       = 4,
    parameter int AddrWidth      = 48,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumPorts-1:0]                  in_req_i,
    output logic [NumPorts-1:0]                  in_gnt_o,
    input  logic [NumPorts*AddrWidth-1:0]        in_addr_i,
    input  logic [NumPorts-1:0]                  in_we_i,
    input  logic [NumPorts*DataWidth-1:0]        in_wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0]      in_strb_i,
    output logic [NumPorts-1:0]                  in_rvalid_o,
    output logic [NumPorts*DataWidth-1:0]        in_rdata_o,
    output logic                                 out_req_o,
    input  logic                                 out_gnt_i,
    output logic [AddrWidth-1:0]                 out_addr_o,
    output logic                                 out_we_o,
    output logic [DataWidth-1:0]                 out_wdata_o,
    output logic [DataWidth/8-1:0]               out_strb_o,
    input  logic                                 out_rvalid_i,
    input  logic [DataWidth-1:0]                 out_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

    localparam int IdxW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam int StrbW = DataWidth / 8;

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    idx_t rr_q, rr_d;
    logic lock_valid_q, lock_valid_d;
    idx_t lock_idx_q, lock_idx_d;
    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    cnt_t cnt_q, cnt_d;
    idx_t id_mem [MaxOutstanding];

    idx_t sel;
    idx_t cand;
    logic found;
    logic full;
    logic push;
    logic pop;
    idx_t head;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        if (lock_valid_q && in_req_i[lock_idx_q]) begin
            sel   = lock_idx_q;
            found = 1'b1;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                cand = idx_t'((int'(rr_q) + i) % NumPorts);
                if (!found && in_req_i[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    assign full      = (cnt_q == cnt_t'(MaxOutstanding));
    assign out_req_o = found && !full;
    assign push      = out_req_o && out_gnt_i;
    // A response with nothing in flight has no owner and is dropped.
    assign pop       = out_rvalid_i && (cnt_q != '0);
    assign head      = id_mem[rptr_q];

    always_comb begin
        out_addr_o  = '0;
        out_we_o    = 1'b0;
        out_wdata_o = '0;
        out_strb_o  = '0;
        in_gnt_o    = '0;
        if (out_req_o) begin
            out_addr_o  = in_addr_i[sel*AddrWidth +: AddrWidth];
            out_we_o    = in_we_i[sel];
            out_wdata_o = in_wdata_i[sel*DataWidth +: DataWidth];
            out_strb_o  = in_strb_i[sel*StrbW +: StrbW];
        end
        if (push) begin
            in_gnt_o[sel] = 1'b1;
        end
    end

    always_comb begin
        in_rvalid_o = '0;
        in_rdata_o  = '0;
        if (pop) begin
            in_rvalid_o[head]                        = 1'b1;
            in_rdata_o[head*DataWidth +: DataWidth]  = out_rdata_i;
        end
    end

    always_comb begin
        rr_d         = rr_q;
        lock_valid_d = 1'b0;
        lock_idx_d   = lock_idx_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        if (push) begin
            rr_d   = (sel == idx_t'(NumPorts - 1)) ? '0 : sel + idx_t'(1);
            wptr_d = (wptr_q == ptr_t'(MaxOutstanding - 1)) ? '0 : wptr_q + ptr_t'(1);
        end else if (out_req_o) begin
            // Stalled downstream: hold this port until it is granted.
            lock_valid_d = 1'b1;
            lock_idx_d   = sel;
        end
        if (pop) begin
            rptr_d = (rptr_q == ptr_t'(MaxOutstanding - 1)) ? '0 : rptr_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            rr_q         <= rr_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: the ID storage has no reset; an entry is read only after it was written, and the pointers/count carry the reset state.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wptr_q] <= sel;
        end
    end

    assign outstanding_o = cnt_q;

`ifndef SYNTHESIS
    locked_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_valid_q |-> in_req_i[lock_idx_q])
        else $warning("protocol error: locked request dropped before grant");

    rvalid_has_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_rvalid_i |-> (cnt_q != '0))
        else $warning("protocol error: response with nothing outstanding, dropped");
`endif

endmodule
